// File: rtl/alu_stim_checker_if.sv
// Vector/result link between the stimulus checker and the ALU under test.
// Latency: none here; the ALU returns dut_c LATENCY cycles after a vector.
// Backpressure: none; the ALU must accept one vector per cycle.
interface alu_stim_checker_if;
  logic [1:0] opcode_o;
  logic [3:0] a_o;
  logic [3:0] b_o;
  logic [4:0] dut_c;

  // Checker side drives vectors and samples the result.
  modport master (output opcode_o, a_o, b_o, input dut_c);
  // ALU side consumes vectors and returns the result.
  modport slave (input opcode_o, a_o, b_o, output dut_c);
endinterface

// File: rtl/alu_stim_checker.sv
// Exhaustive ALU sweep: drives all 1024 {opcode,A,B} vectors and checks dut_c.
// Latency: done rises 1+1024+LATENCY cycles after start is sampled (no early stop).
// Backpressure: none; one vector per cycle, ALU result expected exactly LATENCY later.
module alu_stim_checker #(
  parameter int LATENCY     = 1,    // 1..4; drain counter is 2 bits wide
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  alu_stim_checker_if.master  alu,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [10:0]         err_count,
  output logic [9:0]          fail_idx,
  output logic [4:0]          fail_got,
  output logic [4:0]          fail_exp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [9:0]         vec_idx;
  logic [1:0]         drain_cnt;
  logic               start_run;
  logic               last_vec;
  logic               drain_end;
  logic               cmp_vld;
  logic               mismatch;
  logic [4:0]         exp_cur;

  // Expected value and vector index travel alongside the ALU's own latency.
  logic [LATENCY-1:0] pipe_vld;
  logic [4:0]         pipe_exp [LATENCY];
  logic [9:0]         pipe_idx [LATENCY];

  // Reference result for one vector; operands are 4-bit two's complement
  // sign-extended to the 5-bit result width.
  function automatic logic [4:0] alu_expect(input logic [9:0] v);
    logic [4:0] a5;
    logic [4:0] b5;
    logic [4:0] r;
    a5 = {v[7], v[7:4]};
    b5 = {v[3], v[3:0]};
    case (v[9:8])
      2'b00:   r = a5 + b5;
      2'b01:   r = a5 - b5;
      2'b10:   r = ~a5;
      default: r = {4'b0000, |v[3:0]};
    endcase
    return r;
  endfunction

  assign start_run = start && ((state == IDLE) || (state == DONE));
  assign last_vec  = (vec_idx == 10'd1023);
  assign drain_end = (drain_cnt == 2'(LATENCY - 1));
  assign exp_cur   = alu_expect(vec_idx);
  // Compares only while a run is active, so a stopped run stays frozen.
  assign cmp_vld   = pipe_vld[LATENCY-1] && ((state == RUN) || (state == DRAIN));
  assign mismatch  = cmp_vld && (alu.dut_c != pipe_exp[LATENCY-1]);

  // State register; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and vector/status drive.
  always_comb begin
    state_nxt    = state;
    alu.opcode_o = 2'b00;
    alu.a_o      = 4'h0;
    alu.b_o      = 4'h0;
    busy         = 1'b0;
    done         = 1'b0;
    pass         = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        {alu.opcode_o, alu.a_o, alu.b_o} = vec_idx;
        busy = 1'b1;
        if (STOP_ON_ERR && mismatch) state_nxt = DONE;
        else if (last_vec)           state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (STOP_ON_ERR && mismatch) state_nxt = DONE;
        else if (drain_end)          state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        pass = (err_count == 11'd0);
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Vector index walks 0..1023 in RUN; drain counter times the LATENCY tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_idx   <= 10'd0;
      drain_cnt <= 2'd0;
    end else begin
      if (start_run)         vec_idx <= 10'd0;
      else if (state == RUN) vec_idx <= vec_idx + 10'd1;
      if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
      else                drain_cnt <= 2'd0;
    end
  end

  // Valid tags: one per vector driven in RUN, shifted LATENCY stages deep.
  always_ff @(posedge clk) begin
    if (reset || start_run) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= (state == RUN);
      for (int i = 1; i < LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  // Payload stages carry no reset; they are only consumed when tagged valid.
  always_ff @(posedge clk) begin
    pipe_exp[0] <= exp_cur;
    pipe_idx[0] <= vec_idx;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_exp[i] <= pipe_exp[i-1];
      pipe_idx[i] <= pipe_idx[i-1];
    end
  end

  // Error count and first-failure capture; err_count==0 marks the first miss.
  always_ff @(posedge clk) begin
    if (reset || start_run) begin
      err_count <= 11'd0;
      fail_idx  <= 10'd0;
      fail_got  <= 5'd0;
      fail_exp  <= 5'd0;
    end else if (mismatch) begin
      err_count <= err_count + 11'd1;
      if (err_count == 11'd0) begin
        fail_idx <= pipe_idx[LATENCY-1];
        fail_got <= alu.dut_c;
        fail_exp <= pipe_exp[LATENCY-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_stim_checker.sv
// Scoreboard bench: two checkers (LATENCY 1 free-running, LATENCY 3 stop-on-error).
// Latency: run outcome and done cycle predicted at start, checked when done rises.
// Backpressure: none; behavioural ALUs answer every vector after a fixed delay.
module tb_alu_stim_checker;

  localparam int L0 = 1;
  localparam int L1 = 3;

  typedef struct {
    int cyc;
    int err;
    int pass;
    int fidx;
    int fgot;
    int fexp;
  } rec_t;

  logic        clk;
  logic        reset;
  logic        start0, start1;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [10:0] err_count0, err_count1;
  logic [9:0]  fail_idx0, fail_idx1;
  logic [4:0]  fail_got0, fail_exp0, fail_got1, fail_exp1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_start0 = 0, t_start1 = 0;
  int mode0 = 0, spot0 = 0, mode1 = 0, spot1 = 0;
  int vbad0 = 0, vbad1 = 0;
  rec_t q0[$];
  rec_t q1[$];
  rec_t last0;
  logic [4:0] s1_a, s1_b;

  int spot_idx[6] = '{'h077, 'h088, 'h187, 'h200, 'h300, 'h301};
  int spot_exp[6] = '{5'b01110, 5'b10000, 5'b10001, 5'b11111, 5'b00000, 5'b00001};

  alu_stim_checker_if if0 ();
  alu_stim_checker_if if1 ();

  alu_stim_checker #(.LATENCY(L0), .STOP_ON_ERR(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .alu(if0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
    .fail_idx(fail_idx0), .fail_got(fail_got0), .fail_exp(fail_exp0));

  alu_stim_checker #(.LATENCY(L1), .STOP_ON_ERR(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .alu(if1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .fail_idx(fail_idx1), .fail_got(fail_got1), .fail_exp(fail_exp1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU from the arithmetic definition, on plain integers.
  function automatic int ref_alu(input int v);
    int op, a, b, r;
    op = (v >> 8) & 3;
    a  = (v >> 4) & 15;
    b  = v & 15;
    if (a > 7) a = a - 16;
    if (b > 7) b = b - 16;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = -a - 1;
      default: r = (b != 0) ? 1 : 0;
    endcase
    return r & 31;
  endfunction

  // ALU under test: 0 correct, 1 output stuck at zero, 2 wrong only at one vector.
  function automatic int alu_resp(input int mode, input int spot, input int v);
    if (mode == 1) return 0;
    if (mode == 2 && v == spot) return (~ref_alu(v)) & 31;
    return ref_alu(v);
  endfunction

  // Predicted outcome of one full sweep started in cycle t_req.
  function automatic rec_t predict(input int mode, input int spot, input int lat,
                                   input bit stop, input int t_req);
    rec_t r;
    int e, g;
    r.err = 0; r.fidx = 0; r.fgot = 0; r.fexp = 0;
    r.cyc = t_req + 1 + 1024 + lat;
    for (int v = 0; v < 1024; v++) begin
      e = ref_alu(v);
      g = alu_resp(mode, spot, v);
      if (g != e) begin
        if (r.err == 0) begin r.fidx = v; r.fgot = g; r.fexp = e; end
        r.err++;
        if (stop) begin r.cyc = t_req + 2 + v + lat; break; end
      end
    end
    r.pass = (r.err == 0) ? 1 : 0;
    return r;
  endfunction

  // Behavioural ALUs with 1 and 3 cycles of latency.
  always @(posedge clk)
    if0.dut_c <= 5'(alu_resp(mode0, spot0, int'({if0.opcode_o, if0.a_o, if0.b_o})));

  always @(posedge clk) begin
    s1_a      <= 5'(alu_resp(mode1, spot1, int'({if1.opcode_o, if1.a_o, if1.b_o})));
    s1_b      <= s1_a;
    if1.dut_c <= s1_b;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_idle(input int d, input string tag);
    if (d == 0) begin
      chk({tag, " busy"}, int'(busy0), 0);
      chk({tag, " done"}, int'(done0), 0);
      chk({tag, " pass"}, int'(pass0), 0);
      chk({tag, " err_count"}, int'(err_count0), 0);
      chk({tag, " fail_idx"}, int'(fail_idx0), 0);
      chk({tag, " fail_got"}, int'(fail_got0), 0);
      chk({tag, " fail_exp"}, int'(fail_exp0), 0);
      chk({tag, " vector"}, int'({if0.opcode_o, if0.a_o, if0.b_o}), 0);
    end else begin
      chk({tag, " busy"}, int'(busy1), 0);
      chk({tag, " done"}, int'(done1), 0);
      chk({tag, " pass"}, int'(pass1), 0);
      chk({tag, " err_count"}, int'(err_count1), 0);
      chk({tag, " fail_idx"}, int'(fail_idx1), 0);
      chk({tag, " fail_got"}, int'(fail_got1), 0);
      chk({tag, " fail_exp"}, int'(fail_exp1), 0);
      chk({tag, " vector"}, int'({if1.opcode_o, if1.a_o, if1.b_o}), 0);
    end
  endtask

  // One-cycle start pulse; optionally pushes the predicted outcome.
  task automatic start_dut(input int d, input int mode, input int spot, input bit push);
    @(negedge clk);
    if (d == 0) begin
      mode0 = mode; spot0 = spot; start0 = 1'b1;
      if (push) q0.push_back(predict(mode, spot, L0, 1'b0, cyc));
    end else begin
      mode1 = mode; spot1 = spot; start1 = 1'b1;
      if (push) q1.push_back(predict(mode, spot, L1, 1'b1, cyc));
    end
    @(posedge clk);
    #1;
    if (d == 0) begin start0 = 1'b0; t_start0 = cyc; end
    else        begin start1 = 1'b0; t_start1 = cyc; end
  endtask

  task automatic wait_done(input int d);
    logic dn;
    dn = 1'b0;
    for (int i = 0; i < 1400; i++) begin
      @(negedge clk);
      dn = (d == 0) ? done0 : done1;
      if (dn) break;
    end
    chk((d == 0) ? "dut0 done within budget" : "dut1 done within budget", int'(dn), 1);
  endtask

  // Monitor dut0: vector stream every cycle, run outcome when done rises.
  initial begin
    rec_t r;
    int ve;
    logic dq;
    dq = 1'b0;
    forever begin
      @(negedge clk);
      ve = (busy0 && cyc >= t_start0 && cyc - t_start0 < 1024) ? cyc - t_start0 : 0;
      if (int'({if0.opcode_o, if0.a_o, if0.b_o}) != ve) vbad0++;
      if (done0 && !dq) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut0 done: got done=1, expected no run outstanding");
        end else begin
          r = q0.pop_front();
          last0 = r;
          chk("dut0 done cycle", cyc, r.cyc);
          chk("dut0 err_count", int'(err_count0), r.err);
          chk("dut0 pass", int'(pass0), r.pass);
          chk("dut0 fail_idx", int'(fail_idx0), r.fidx);
          chk("dut0 fail_got", int'(fail_got0), r.fgot);
          chk("dut0 fail_exp", int'(fail_exp0), r.fexp);
          chk("dut0 vector stream errors", vbad0, 0);
          vbad0 = 0;
        end
      end
      dq = done0;
    end
  end

  // Monitor dut1: same checks for the stop-on-error instance.
  initial begin
    rec_t r;
    int ve;
    logic dq;
    dq = 1'b0;
    forever begin
      @(negedge clk);
      ve = (busy1 && cyc >= t_start1 && cyc - t_start1 < 1024) ? cyc - t_start1 : 0;
      if (int'({if1.opcode_o, if1.a_o, if1.b_o}) != ve) vbad1++;
      if (done1 && !dq) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1 done: got done=1, expected no run outstanding");
        end else begin
          r = q1.pop_front();
          chk("dut1 done cycle", cyc, r.cyc);
          chk("dut1 err_count", int'(err_count1), r.err);
          chk("dut1 pass", int'(pass1), r.pass);
          chk("dut1 fail_idx", int'(fail_idx1), r.fidx);
          chk("dut1 fail_got", int'(fail_got1), r.fgot);
          chk("dut1 fail_exp", int'(fail_exp1), r.fexp);
          chk("dut1 vector stream errors", vbad1, 0);
          vbad1 = 0;
        end
      end
      dq = done1;
    end
  end

  initial begin
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle(0, "reset dut0");
    chk_idle(1, "reset dut1");

    // Reset beats start.
    start0 = 1'b1;
    @(negedge clk);
    chk("reset priority busy", int'(busy0), 0);
    reset  = 1'b0;
    start0 = 1'b0;

    // Clean sweep, then result hold in DONE.
    start_dut(0, 0, 0, 1'b1);
    wait_done(0);
    repeat (5) @(negedge clk);
    chk("hold done", int'(done0), 1);
    chk("hold pass", int'(pass0), last0.pass);
    chk("hold err_count", int'(err_count0), last0.err);

    // Spot vectors: ALU wrong at exactly one vector exposes the expected value.
    for (int i = 0; i < 6; i++) begin
      start_dut(0, 2, spot_idx[i], 1'b1);
      wait_done(0);
      chk("spot fail_idx", int'(fail_idx0), spot_idx[i]);
      chk("spot fail_exp", int'(fail_exp0), spot_exp[i]);
    end

    // Stuck-at-zero ALU, full run.
    start_dut(0, 1, 0, 1'b1);
    wait_done(0);
    chk("stuck0 fail_idx", int'(fail_idx0), 1);
    chk("stuck0 fail_got", int'(fail_got0), 0);
    chk("stuck0 fail_exp", int'(fail_exp0), 1);
    chk("stuck0 err nonzero", int'(err_count0 != 11'd0), 1);

    // Reset in the cycle vector 500 is driven, then a clean run.
    start_dut(0, 1, 0, 1'b0);
    do @(negedge clk); while (cyc < t_start0 + 500);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_idle(0, "midrun reset");
    start_dut(0, 0, 0, 1'b1);
    wait_done(0);

    // start held through a failing run; restart from DONE clears err_count.
    @(negedge clk);
    mode0  = 1;
    start0 = 1'b1;
    q0.push_back(predict(1, 0, L0, 1'b0, cyc));
    @(posedge clk);
    #1 t_start0 = cyc;
    wait_done(0);
    mode0 = 0;
    q0.push_back(predict(0, 0, L0, 1'b0, cyc));
    @(posedge clk);
    #1;
    t_start0 = cyc;
    start0   = 1'b0;
    @(negedge clk);
    chk("restart busy", int'(busy0), 1);
    chk("restart err_count", int'(err_count0), 0);
    wait_done(0);

    // Stop-on-error instance: clean, stuck-at-zero, single bad vector.
    start_dut(1, 0, 0, 1'b1);
    wait_done(1);
    start_dut(1, 1, 0, 1'b1);
    wait_done(1);
    chk("stop err_count", int'(err_count1), 1);
    start_dut(1, 2, 'h187, 1'b1);
    wait_done(1);

    repeat (3) @(negedge clk);
    chk("dut0 runs outstanding", q0.size(), 0);
    chk("dut1 runs outstanding", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_stim_checker.md
ALU_STIM_CHECKER -- requirements
Module: alu_stim_checker

Interface
REQ-001 Parameter LATENCY, default 1: cycles from a vector being driven on opcode_o/a_o/b_o to its result being valid on dut_c; legal range 1..4.
REQ-002 Parameter STOP_ON_ERR, default 0: 1 = end the run at the first mismatch; 0 = run the full sweep.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  run request, sampled in IDLE and DONE only.
REQ-006 opcode_o  output  2  opcode to the ALU under test: 00 add, 01 sub, 10 not A, 11 reduction-OR of B.
REQ-007 a_o  output  4  operand A to the ALU, two's complement.
REQ-008 b_o  output  4  operand B to the ALU, two's complement.
REQ-009 dut_c  input  5  registered result returned by the ALU.
REQ-010 busy  output  1  high in RUN and DRAIN.
REQ-011 done  output  1  high in DONE.
REQ-012 pass  output  1  high in DONE when err_count is 0.
REQ-013 err_count  output  11  number of mismatches in the current or last run.
REQ-014 fail_idx  output  10  vector index of the first mismatch.
REQ-015 fail_got  output  5  dut_c value at the first mismatch.
REQ-016 fail_exp  output  5  expected value at the first mismatch.

Function
REQ-017 The block SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE or DONE with start=1 SHALL move to RUN on the next edge, clearing the following at that edge: the vector index, err_count, fail_idx, fail_got, fail_exp and the expected pipeline.
REQ-019 start SHALL be ignored in RUN and DRAIN.
REQ-020 In RUN, vector index i (10 bits) SHALL be driven as {opcode_o, a_o, b_o} = i, B least significant, incrementing by one per cycle from 0 to 1023.
REQ-021 After index 1023 is driven, RUN SHALL go to DRAIN for exactly LATENCY cycles, then to DONE.
REQ-022 opcode_o, a_o and b_o SHALL be 0 in IDLE, DRAIN and DONE.
REQ-023 Expected result, 5-bit two's complement with operands sign-extended to 5 bits:
  - add: A+B
  - sub: A-B
  - not A: ~A, sign-extended
  - reduction-OR: {4'b0, |B}
REQ-024 The expected value and index SHALL pass through a LATENCY-deep valid-tagged pipeline.
REQ-025 dut_c SHALL be compared only in cycles where the pipeline output is valid; no compare SHALL happen in any other cycle.
REQ-026 On a mismatch, err_count SHALL increment.
REQ-027 On the first mismatch of a run, fail_idx, fail_got and fail_exp SHALL be captured, and SHALL then be held until the next start or reset.
REQ-028 With STOP_ON_ERR=1, the first mismatch SHALL move the block to DONE on the next edge, and no further compares SHALL be made.
REQ-029 The cycle count from start being sampled to done going high SHALL be 1+1024+LATENCY when no early stop occurs.
REQ-030 DONE SHALL hold all result outputs stable until start or reset.

Reset
REQ-031 reset=1 SHALL force IDLE from any state, including mid-RUN and mid-DRAIN.
REQ-032 reset=1 SHALL clear all outputs and pipeline valid bits to 0.
REQ-033 No compare SHALL occur in the cycle reset is high.
REQ-034 reset SHALL take priority over start.

Verification
REQ-035 Correct ALU (LATENCY=1) looped back, pulse start -> done high 1026 cycles after start is sampled, err_count=0, pass=1.
REQ-036 Spot vectors on a correct ALU SHALL each compare equal:
  - add 7+7 -> 01110
  - add -8+-8 -> 10000
  - sub -8-7 -> 10001
  - not 0 -> 11111
  - OR B=0 -> 00000
  - OR B=1 -> 00001
REQ-037 dut_c tied to 0, STOP_ON_ERR=0 -> full run, pass=0, err_count nonzero, fail_idx=1, fail_got=0, fail_exp=1.
REQ-038 dut_c tied to 0, STOP_ON_ERR=1 -> DONE entered the cycle after the index-1 compare, err_count=1.
REQ-039 reset pulsed at vector 500 of a run -> IDLE next cycle with all outputs 0; a new start then gives a complete clean run.
REQ-040 start held high through RUN -> no restart until DONE; in DONE, start=1 begins a new run with err_count cleared.
